serial_addsub_unit: RTL and testbench

- Parametrised bit-serial adder/subtractor: successor to the fixed 4-bit serial adder, generalised to WIDTH bits.
- Adds a start/busy/done handshake, parallel operand load, subtract mode, carry-out and signed-overflow flags.
- One full-adder cell plus a carry flop processes one bit per clock, LSB first.
- Sits beside the existing serial datapath blocks as the reusable arithmetic engine for small-area designs.

---
 rtl/serial_addsub_pkg.sv | 24 ++
 rtl/full_adder.sv | 20 ++
 rtl/serial_addsub_unit.sv | 105 ++++++++++
 tb/tb_serial_addsub_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// +-------------------------------------------------------------------------+
// | serial_addsub_pkg: shared constants, state encoding and helpers         |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package serial_addsub_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Bit-counter width; never below 1 so WIDTH=2 still gets a real counter.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// +-------------------------------------------------------------------------+
// | full_adder: single-bit full adder cell                                  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module full_adder (
  input  logic x,
  input  logic y,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = x ^ y ^ Cin;
  assign Cout = (x & y) | (Cin & (x ^ y));

endmodule

`default_nettype wire

// File: rtl/serial_addsub_unit.sv
// +-------------------------------------------------------------------------+
// | serial_addsub_unit: WIDTH-bit bit-serial add/sub, LSB first, one bit    |
// | per clock. Optional macro SERIAL_ADDSUB_ACCUM_EN adds the acc input.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module serial_addsub_unit
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_ACCUM_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("serial_addsub_unit: WIDTH out of range");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] load_a;

`ifdef SERIAL_ADDSUB_ACCUM_EN
  // In IDLE the A register still holds the previous result.
  assign load_a = acc ? a_sr : a;
`else
  assign load_a = a;
`endif

  full_adder u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .Cin  (carry),
    .S    (fa_sum),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= load_a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= CNT_W'(WIDTH - 1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr  <= {fa_sum, a_sr[WIDTH-1:1]};
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          cnt   <= cnt - 1'b1;
          // On the MSB step, carry still holds the carry into the MSB.
          if (cnt == '0) begin
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign result = a_sr;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
// +-------------------------------------------------------------------------+
// | tb_serial_addsub_unit: random + directed bench, WIDTH = 8, 2 and 32     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_serial_addsub_unit;

  localparam int NI = 3;
  localparam int WID [NI] = '{8, 2, 32};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        acc = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [NI-1:0] busy_o, done_o, cout_o, ovf_o;
  logic [7:0]    res8;
  logic [1:0]    res2;
  logic [31:0]   res32;
  logic [31:0]   res_o [NI];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  always_comb begin
    res_o[0] = {24'd0, res8};
    res_o[1] = {30'd0, res2};
    res_o[2] = res32;
  end

  serial_addsub_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]),
`ifdef SERIAL_ADDSUB_ACCUM_EN
    .acc(acc),
`endif
    .busy(busy_o[0]), .done(done_o[0]), .result(res8), .cout(cout_o[0]), .ovf(ovf_o[0])
  );

  serial_addsub_unit #(.WIDTH(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start), .sub(sub), .a(a[1:0]), .b(b[1:0]),
`ifdef SERIAL_ADDSUB_ACCUM_EN
    .acc(acc),
`endif
    .busy(busy_o[1]), .done(done_o[1]), .result(res2), .cout(cout_o[1]), .ovf(ovf_o[1])
  );

  serial_addsub_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rstn(rstn), .start(start), .sub(sub), .a(a), .b(b),
`ifdef SERIAL_ADDSUB_ACCUM_EN
    .acc(acc),
`endif
    .busy(busy_o[2]), .done(done_o[2]), .result(res32), .cout(cout_o[2]), .ovf(ovf_o[2])
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    longint res;
    bit     c;
    bit     v;
  } op_t;

  // Reference arithmetic: unsigned result/carry and signed-range overflow.
  function automatic op_t ref_op(input int w, input longint ua_in, input longint ub_in, input bit s);
    op_t    o;
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua = ua_in & mask;
    longint ub = ub_in & mask;
    longint sa = (ua >= half) ? ua - (mask + 1) : ua;
    longint sb = (ub >= half) ? ub - (mask + 1) : ub;
    longint sr;
    if (s) begin
      o.res = (ua - ub) & mask;
      o.c   = (ua >= ub);
      sr    = sa - sb;
    end else begin
      o.res = (ua + ub) & mask;
      o.c   = ((ua + ub) > mask);
      sr    = sa + sb;
    end
    o.v = (sr > half - 1) || (sr < -half);
    return o;
  endfunction

  // Cycle-level model: cd counts remaining busy cycles, cd==1 is the done cycle.
  int  cd [NI];
  op_t pend [NI];
  op_t held [NI];

  always @(posedge clk or negedge rstn) begin
    for (int k = 0; k < NI; k++) begin
      if (!rstn) begin
        cd[k]   = 0;
        held[k] = '{0, 1'b0, 1'b0};
      end else if (cd[k] > 0) begin
        cd[k]--;
        if (cd[k] == 1) held[k] = pend[k];
      end else if (start) begin
`ifdef SERIAL_ADDSUB_ACCUM_EN
        pend[k] = ref_op(WID[k], acc ? held[k].res : longint'(a), longint'(b), sub);
`else
        pend[k] = ref_op(WID[k], longint'(a), longint'(b), sub);
`endif
        cd[k] = WID[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("busy_w%0d", WID[k]), longint'(busy_o[k]), longint'(cd[k] > 0));
        check($sformatf("done_w%0d", WID[k]), longint'(done_o[k]), longint'(cd[k] == 1));
        if (cd[k] <= 1) begin
          check($sformatf("result_w%0d", WID[k]), longint'(res_o[k]), held[k].res);
          check($sformatf("cout_w%0d", WID[k]), longint'(cout_o[k]), longint'(held[k].c));
          check($sformatf("ovf_w%0d", WID[k]), longint'(ovf_o[k]), longint'(held[k].v));
        end
      end
    end
  end

  // Issue one op on the 8-bit instance and wait (bounded) for its done pulse.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input bit is, input bit iacc,
                        output logic [7:0] r, output bit c, output bit v, output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = is; acc = iacc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; acc = 1'b0;
    lat = 1;
    while (!done_o[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = res_o[0][7:0];
    c = cout_o[0];
    v = ovf_o[0];
  endtask

  logic [7:0] r;
  bit         c, v;
  int         lat, busy_cycles;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", longint'(busy_o), 0);
    check("reset_done", longint'(done_o), 0);
    check("reset_result", longint'(res_o[2]), 0);
    check("reset_flags", longint'({cout_o, ovf_o}), 0);
    @(negedge clk);
    rstn = 1'b1;

    run_op(32'h35, 32'h4A, 1'b0, 1'b0, r, c, v, lat);
    check("lat_35p4a", lat, 9);
    check("res_35p4a", r, 8'h7F);
    check("flags_35p4a", {c, v}, 2'b00);
    run_op(32'h7F, 32'h01, 1'b0, 1'b0, r, c, v, lat);
    check("res_7fp01", r, 8'h80);
    check("flags_7fp01", {c, v}, 2'b01);
    run_op(32'hFF, 32'h01, 1'b0, 1'b0, r, c, v, lat);
    check("res_ffp01", r, 8'h00);
    check("flags_ffp01", {c, v}, 2'b10);
    run_op(32'h10, 32'h20, 1'b1, 1'b0, r, c, v, lat);
    check("res_10m20", r, 8'hF0);
    check("flags_10m20", {c, v}, 2'b00);
    run_op(32'h80, 32'h01, 1'b1, 1'b0, r, c, v, lat);
    check("res_80m01", r, 8'h7F);
    check("flags_80m01", {c, v}, 2'b11);

    // Start pulses while busy must be ignored.
    @(negedge clk);
    a = 32'h01; b = 32'h01; sub = 1'b0; start = 1'b1;
    busy_cycles = 0;
    for (int i = 1; i < 40 && !done_o[0]; i++) begin
      @(negedge clk);
      start = (i == 3 || i == 5);
      if (start) a = 32'hAA;
      if (busy_o[0]) busy_cycles++;
    end
    start = 1'b0;
    check("res_ignore", longint'(res_o[0]), 2);
    check("busy_cycles", busy_cycles, 9);

    // Abort mid-operation with reset.
    @(negedge clk);
    a = 32'h33; b = 32'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_busy", longint'(busy_o), 0);
    check("abort_done", longint'(done_o), 0);
    check("abort_result", longint'(res_o[0]), 0);
    check("abort_flags", longint'({cout_o, ovf_o}), 0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(32'h33, 32'h11, 1'b0, 1'b0, r, c, v, lat);
    check("res_after_abort", r, 8'h44);

`ifdef SERIAL_ADDSUB_ACCUM_EN
    run_op(32'h05, 32'h03, 1'b0, 1'b0, r, c, v, lat);
    check("res_acc_first", r, 8'h08);
    run_op(32'hEE, 32'h10, 1'b0, 1'b1, r, c, v, lat);
    check("res_acc_second", r, 8'h18);
`endif

    // Start held high: back-to-back ops.
    @(negedge clk);
    a = 32'h12345678; b = 32'h0F0F0F0F; sub = 1'b1; start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      sub   = 1'($urandom);
      acc   = 1'($urandom);
      a     = $urandom;
      b     = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
